// File: rtl/spi_apb_regif.sv
// spi_apb_regif: APB register front-end for the SPI master with a TX word FIFO, RX holding register and interrupt
// Ports: PCLK/PRESETn clock and async active-low reset; PSEL/PENABLE/PWRITE/PADDR/PWDATA in and
// PRDATA/PREADY/PSLVERR out form the zero-wait-state APB slave; SPISR/MRDATA come from the SPI master;
// SPICR_1/SPICR_2/MADDR/MWDATA drive the master; irq is the registered level interrupt.
// Define SPI_APB_TXFIFO_EN for a FIFO_DEPTH-word TX FIFO; otherwise TX is a single-entry holding register.
module spi_apb_regif #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic [7:0]  SPISR,
  input  logic [31:0] MRDATA,
  output logic [7:0]  SPICR_1,
  output logic [7:0]  SPICR_2,
  output logic [7:0]  MADDR,
  output logic [31:0] MWDATA,
  output logic        irq
);
`ifdef SPI_APB_TXFIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  // always 1: single-entry holding register
  localparam int DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, lvl;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [7:0]    cr1_q, addr_q;
  logic          cr2_q, done_q, rxv_q, txovf_q, rxovr_q, irq_q, pready_q, pslverr_q;
  logic [2:0]    ien_q;
  logic [31:0]   rx_q, prdata_q, rdata;
  logic          rxv_d, txovf_d, rxovr_d, irq_d, pslverr_d;
  logic [31:0]   prdata_d;
  logic          empty, full, ok, setup, wr, rd, done_ev, pop, push_req, push, rx_ev, rxdr_rd, stat_w;
  logic [2:0]    off;
  logic          unused;
  assign unused   = ^PADDR[1:0];
  assign lvl      = wr_ptr_q - rd_ptr_q;
  assign empty    = wr_ptr_q == rd_ptr_q;
  assign full     = lvl == PW'(DEPTH);
  assign wr_idx   = IW'(wr_ptr_q % DEPTH);
  assign rd_idx   = IW'(rd_ptr_q % DEPTH);
  assign ok       = PADDR[7:5] == 3'b0;
  assign off      = PADDR[4:2];
  assign setup    = PSEL & ~PENABLE;
  // PREADY is high only during ACCESS, so it qualifies the commit
  assign wr       = PSEL & PENABLE & pready_q & PWRITE & ok;
  assign rd       = PSEL & PENABLE & pready_q & ~PWRITE & ok;
  assign done_ev  = SPISR[0] & ~done_q;
  assign pop      = done_ev & cr2_q & ~empty;
  assign push_req = wr & (off == 3'd3);
  // a simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign push     = push_req & (~full | pop);
  assign rx_ev    = done_ev & ~cr2_q;
  assign rxdr_rd  = rd & (off == 3'd4);
  assign stat_w   = wr & (off == 3'd6);
  assign MWDATA   = empty ? '0 : mem_q[rd_idx];
  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata = {24'b0, cr1_q};
      3'd1: rdata = {31'b0, cr2_q};
      3'd2: rdata = {24'b0, SPISR};
      3'd3: rdata = '0;
      3'd4: rdata = rx_q;
      3'd5: rdata = {24'b0, addr_q};
      3'd6: rdata = {21'b0, rxovr_q, txovf_q, rxv_q, 1'b0, full, empty, 5'(lvl)};
      3'd7: rdata = {29'b0, ien_q};
    endcase
  end
  always_comb begin
    pslverr_d = setup & (~ok | ((off == 3'd3) & (~PWRITE | full)));
    prdata_d  = (setup & ~PWRITE & ~pslverr_d) ? rdata : '0;
    rxv_d     = rx_ev | (rxv_q & ~rxdr_rd);
    // set events take priority over a coincident W1C clear
    txovf_d   = (push_req & ~push) | (txovf_q & ~(stat_w & PWDATA[9]));
    rxovr_d   = (rx_ev & rxv_q & ~rxdr_rd) | (rxovr_q & ~(stat_w & PWDATA[10]));
    irq_d     = (ien_q[0] & empty) | (ien_q[1] & rxv_q) | (ien_q[2] & (txovf_q | rxovr_q));
  end
  always_ff @(posedge PCLK)
    if (push) mem_q[wr_idx] <= PWDATA;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cr1_q     <= '0;
      cr2_q     <= 1'b0;
      addr_q    <= '0;
      ien_q     <= '0;
      rx_q      <= '0;
      done_q    <= 1'b0;
      rxv_q     <= 1'b0;
      txovf_q   <= 1'b0;
      rxovr_q   <= 1'b0;
      irq_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_q + (push ? PW'(1) : PW'(0));
      rd_ptr_q  <= rd_ptr_q + (pop ? PW'(1) : PW'(0));
      cr1_q     <= (wr & (off == 3'd0)) ? PWDATA[7:0] : cr1_q;
      cr2_q     <= (wr & (off == 3'd1)) ? PWDATA[0] : cr2_q;
      addr_q    <= (wr & (off == 3'd5)) ? PWDATA[7:0] : addr_q;
      ien_q     <= (wr & (off == 3'd7)) ? PWDATA[2:0] : ien_q;
      rx_q      <= rx_ev ? MRDATA : rx_q;
      done_q    <= SPISR[0];
      rxv_q     <= rxv_d;
      txovf_q   <= txovf_d;
      rxovr_q   <= rxovr_d;
      irq_q     <= irq_d;
      pready_q  <= setup;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign SPICR_1 = cr1_q;
  assign SPICR_2 = {7'b0, cr2_q};
  assign MADDR   = addr_q;
  assign irq     = irq_q;
endmodule

// File: tb/tb_spi_apb_regif.sv
// tb_spi_apb_regif: directed plus randomized bench for spi_apb_regif against a queue-based model
module tb_spi_apb_regif;
`ifdef SPI_APB_TXFIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif
  logic        PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [7:0]  PADDR = 0, SPISR = 0;
  logic [31:0] PWDATA = 0, MRDATA = 0;
  logic [31:0] PRDATA, MWDATA;
  logic        PREADY, PSLVERR, irq;
  logic [7:0]  SPICR_1, SPICR_2, MADDR;
  int passed = 0, total = 0;
  logic [31:0] q[$];
  logic        cr2_m = 0, rxv_m = 0, ovf_m = 0, ovr_m = 0;
  logic [31:0] rx_m = 0;
  logic [2:0]  ien_m = 0;

  spi_apb_regif #(.FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SPISR(SPISR), .MRDATA(MRDATA), .SPICR_1(SPICR_1), .SPICR_2(SPICR_2), .MADDR(MADDR),
    .MWDATA(MWDATA), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] stat_m();
    return {21'b0, ovr_m, ovf_m, rxv_m, 1'b0, q.size() == D, q.size() == 0, 5'(q.size())};
  endfunction
  function automatic logic irq_m();
    return (ien_m[0] && q.size() == 0) || (ien_m[1] && rxv_m) || (ien_m[2] && (ovf_m || ovr_m));
  endfunction
  function automatic logic [31:0] head_m();
    return (q.size() != 0) ? q[0] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic apb(input bit w, input logic [7:0] a, input logic [31:0] d, input bit dn,
                     output logic [31:0] r, output logic e, output logic y);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1;
    if (dn) SPISR[0] = 1;
    r = PRDATA; e = PSLVERR; y = PREADY;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0; SPISR[0] = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic ee, input string tag);
    logic [31:0] r; logic e, y;
    apb(1, a, d, 0, r, e, y);
    chk({tag, " ready"}, 32'(y), 32'd1);
    chk({tag, " err"}, 32'(e), 32'(ee));
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input logic ee, input string tag);
    logic [31:0] r; logic e, y;
    apb(0, a, 0, 0, r, e, y);
    chk({tag, " ready"}, 32'(y), 32'd1);
    chk({tag, " data"}, r, exp);
    chk({tag, " err"}, 32'(e), 32'(ee));
  endtask

  task automatic push(input logic [31:0] d);
    logic f;
    f = q.size() == D;
    wr(8'h0C, d, f, "txdr_push");
    if (f) ovf_m = 1; else q.push_back(d);
  endtask

  task automatic pulse(input logic [31:0] d);
    MRDATA = d;
    @(posedge PCLK); #1; SPISR[0] = 1;
    @(posedge PCLK); #1; SPISR[0] = 0;
    if (cr2_m) begin
      if (q.size() != 0) void'(q.pop_front());
    end else begin
      if (rxv_m) ovr_m = 1;
      rx_m = d; rxv_m = 1;
    end
  endtask

  task automatic rd_rx();
    rd(8'h10, rx_m, 0, "rxdr");
    rxv_m = 0;
  endtask

  task automatic rd_stat(input string tag);
    rd(8'h18, stat_m(), 0, tag);
  endtask

  task automatic chk_irq(input string tag);
    @(posedge PCLK); #1;
    chk(tag, 32'(irq), 32'(irq_m()));
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " PRDATA"}, PRDATA, 0);
    chk({tag, " PREADY"}, 32'(PREADY), 0);
    chk({tag, " PSLVERR"}, 32'(PSLVERR), 0);
    chk({tag, " SPICR_1"}, 32'(SPICR_1), 0);
    chk({tag, " SPICR_2"}, 32'(SPICR_2), 0);
    chk({tag, " MADDR"}, 32'(MADDR), 0);
    chk({tag, " MWDATA"}, MWDATA, 0);
    chk({tag, " irq"}, 32'(irq), 0);
  endtask

  initial begin
    logic [31:0] c, r;
    logic e, y;
    repeat (3) @(posedge PCLK);
    #1;
    chk_outs_zero("reset");
    PRESETn = 1;
    rd(8'h00, 0, 0, "cr1_rst");
    rd(8'h04, 0, 0, "cr2_rst");
    rd(8'h14, 0, 0, "addr_rst");
    rd(8'h1C, 0, 0, "ien_rst");
    rd(8'h18, 32'h20, 0, "stat_rst");
    chk_irq("irq_rst");
    c = $urandom;
    wr(8'h00, c, 0, "cr1_wr");
    chk("SPICR_1", 32'(SPICR_1), {24'b0, c[7:0]});
    rd(8'h00, {24'b0, c[7:0]}, 0, "cr1_rd");
    c = $urandom;
    wr(8'h14, c, 0, "addr_wr");
    chk("MADDR", 32'(MADDR), {24'b0, c[7:0]});
    rd(8'h14, {24'b0, c[7:0]}, 0, "addr_rd");
    wr(8'h04, 32'hFFFF_FFFF, 0, "cr2_wr");
    cr2_m = 1;
    chk("SPICR_2", 32'(SPICR_2), 32'd1);
    rd(8'h04, 32'd1, 0, "cr2_rd");
    SPISR = 8'($urandom) & 8'hFE;
    rd(8'h08, {24'b0, SPISR}, 0, "sr_rd");
    SPISR = 0;
    // push and pop
    push(32'hA5A5_0001);
    push(32'h0000_00FF);
    chk("mwdata_head", MWDATA, head_m());
    pulse($urandom);
    chk("mwdata_pop1", MWDATA, head_m());
    rd_stat("stat_pop1");
    pulse($urandom);
    chk("mwdata_pop2", MWDATA, head_m());
    rd_stat("stat_pop2");
    // overflow and W1C
    repeat (D + 1) push($urandom);
    rd_stat("stat_ovf");
    wr(8'h18, 32'h200, 0, "stat_w1c_ovf");
    ovf_m = 0;
    rd_stat("stat_ovf_clr");
    repeat (D) begin
      pulse($urandom);
      chk("mwdata_drain", MWDATA, head_m());
    end
    // receive
    wr(8'h04, 0, 0, "cr2_rx");
    cr2_m = 0;
    pulse(32'hDEAD_BEEF);
    rd_stat("stat_rxv");
    rd_rx();
    rd_stat("stat_rxv_clr");
    pulse($urandom);
    pulse($urandom);
    rd_stat("stat_rxovr");
    rd_rx();
    wr(8'h18, 32'h400, 0, "stat_w1c_ovr");
    ovr_m = 0;
    rd_stat("stat_ovr_clr");
    // interrupts
    wr(8'h1C, 32'h3, 0, "ien_wr");
    ien_m = 3'h3;
    chk_irq("irq_empty");
    push($urandom);
    chk_irq("irq_pushed");
    pulse($urandom);
    chk_irq("irq_rx");
    rd_rx();
    wr(8'h1C, 32'h4, 0, "ien_err");
    ien_m = 3'h4;
    chk_irq("irq_none");
    // errors
    rd(8'h20, 0, 1, "bad_rd");
    wr(8'h20, $urandom, 1, "bad_wr");
    rd(8'h0C, 0, 1, "txdr_rd");
    // push and pop coinciding on a full FIFO
    wr(8'h04, 1, 0, "cr2_tx");
    cr2_m = 1;
    while (q.size() < D) push($urandom);
    c = $urandom;
    apb(1, 8'h0C, c, 1, r, e, y);
    void'(q.pop_front());
    q.push_back(c);
    rd_stat("stat_full_pushpop");
    chk("mwdata_full_pushpop", MWDATA, head_m());
    // randomized mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: push($urandom);
        1: pulse($urandom);
        2: rd_stat("stat_rand");
        3: rd_rx();
        4: begin
          c = $urandom;
          wr(8'h04, c, 0, "cr2_rand");
          cr2_m = c[0];
        end
        default: begin
          c = $urandom;
          wr(8'h18, c, 0, "stat_w1c_rand");
          if (c[9]) ovf_m = 0;
          if (c[10]) ovr_m = 0;
        end
      endcase
      chk("mwdata_rand", MWDATA, head_m());
    end
    wr(8'h1C, 32'h7, 0, "ien_all");
    ien_m = 3'h7;
    chk_irq("irq_rand");
    // reset during ACCESS
    wr(8'h00, 32'h5A, 0, "cr1_5a");
    if (q.size() == 0) push(32'h1234_5678);
    @(posedge PCLK); #1;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 8'h00;
    @(posedge PCLK); #1;
    PENABLE = 1;
    chk("mid_ready", 32'(PREADY), 32'd1);
    chk("mid_cr1", 32'(SPICR_1), 32'h5A);
    #2 PRESETn = 0;
    #1;
    chk_outs_zero("mid_reset");
    PSEL = 0; PENABLE = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
